sim_bus_memories: RTL and testbench

- Simulation-only memory model that replaces real memory behind the CPU core.
- Provides a read-only instruction port and a read/write data port, both in the codebase's Bus_if signal convention (flattened here).
- Both storage arrays are plain unpacked word arrays, so benches can preload them hierarchically ($readmemh, direct loops) and inspect them.
- The data port exports a merged-write debug word, so benches can log every store as "[addr16]=0xWORD".

---
 rtl/bus_pkg.sv | 22 ++
 rtl/sim_word_ram.sv | 40 ++++
 rtl/sim_bus_memories.sv | 70 +++++++
 tb/tb_sim_bus_memories.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus types and the byte-lane merge used by the simulated data memory.
package bus_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;
    typedef logic [3:0]  byte_mask_t;

    localparam int BYTE_LANES = 4;

    // Lane i takes new_w when mask[i] is set, otherwise keeps old_w.
    function automatic word_t merge_bytes(word_t old_w, word_t new_w, byte_mask_t mask);
        word_t r;
        r = old_w;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (mask[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sim_word_ram.sv
// Plain word array with combinational read and an optional clocked write port.
module sim_word_ram
    import bus_pkg::*;
#(
    parameter int WORDS    = 65536,
    parameter bit WRITE_EN = 1'b1,
    parameter int AW       = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_index,
    input  logic          i_re,
    input  logic          i_we,
    input  word_t         i_wdata,
    output word_t         o_rdata,
    output word_t         o_word
);

    // Left without reset so preloaded images survive reset.
    word_t r_mem [WORDS];

    logic w_unused_ports;

    assign o_word  = r_mem[i_index];
    assign o_rdata = (rst && i_re) ? r_mem[i_index] : '0;

    generate
        if (WRITE_EN) begin : g_write
            always_ff @(posedge clk) begin
                if (rst && i_we) begin
                    r_mem[i_index] <= i_wdata;
                end
            end
            assign w_unused_ports = 1'b0;
        end else begin : g_no_write
            assign w_unused_ports = &{1'b0, i_we, i_wdata, clk};
        end
    endgenerate

endmodule

// File: rtl/sim_bus_memories.sv
// Simulation memory behind the CPU: read-only instruction port plus byte-masked data port.
module sim_bus_memories
    import bus_pkg::*;
#(
    parameter int INST_WORDS = 65536,
    parameter int DATA_WORDS = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  addr_t      inst_address,
    input  logic       inst_read,
    output word_t      inst_rdata,
    output logic       inst_stall,
    input  addr_t      data_address,
    input  logic       data_read,
    input  logic       data_write,
    input  word_t      data_wdata,
    input  byte_mask_t data_mask,
    output word_t      data_rdata,
    output logic       data_stall,
    output word_t      data_w
);

    localparam int IAW = $clog2(INST_WORDS);
    localparam int DAW = $clog2(DATA_WORDS);

    logic [IAW-1:0] w_inst_index;
    logic [DAW-1:0] w_data_index;
    word_t          w_data_old;
    word_t          w_inst_word_unused;
    logic           w_unused_addr_bits;

    // Byte offset dropped; bits above the array depth alias.
    assign w_inst_index = inst_address[IAW+1:2];
    assign w_data_index = data_address[DAW+1:2];
    assign w_unused_addr_bits = &{1'b0, inst_address, data_address, w_inst_word_unused};

    assign inst_stall = 1'b0;
    assign data_stall = 1'b0;
    assign data_w     = merge_bytes(w_data_old, data_wdata, data_mask);

    sim_word_ram #(
        .WORDS    (INST_WORDS),
        .WRITE_EN (1'b0)
    ) inst_mem (
        .clk     (clk),
        .rst     (rst),
        .i_index (w_inst_index),
        .i_re    (inst_read),
        .i_we    (1'b0),
        .i_wdata ('0),
        .o_rdata (inst_rdata),
        .o_word  (w_inst_word_unused)
    );

    sim_word_ram #(
        .WORDS    (DATA_WORDS),
        .WRITE_EN (1'b1)
    ) data_ram (
        .clk     (clk),
        .rst     (rst),
        .i_index (w_data_index),
        .i_re    (data_read),
        .i_we    (data_write),
        .i_wdata (data_w),
        .o_rdata (data_rdata),
        .o_word  (w_data_old)
    );

endmodule

// File: tb/tb_sim_bus_memories.sv
// Directed bench for sim_bus_memories: fetches, masked stores, aliasing, read/write overlap, reset.
module tb_sim_bus_memories;
    import bus_pkg::*;

    logic       clk;
    logic       rst;
    addr_t      inst_address;
    logic       inst_read;
    word_t      inst_rdata;
    logic       inst_stall;
    addr_t      data_address;
    logic       data_read;
    logic       data_write;
    word_t      data_wdata;
    byte_mask_t data_mask;
    word_t      data_rdata;
    logic       data_stall;
    word_t      data_w;

    int checks   = 0;
    int failures = 0;

    sim_bus_memories dut (
        .clk          (clk),
        .rst          (rst),
        .inst_address (inst_address),
        .inst_read    (inst_read),
        .inst_rdata   (inst_rdata),
        .inst_stall   (inst_stall),
        .data_address (data_address),
        .data_read    (data_read),
        .data_write   (data_write),
        .data_wdata   (data_wdata),
        .data_mask    (data_mask),
        .data_rdata   (data_rdata),
        .data_stall   (data_stall),
        .data_w       (data_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] addr);
        data_address = addr;
        data_read    = 1'b1;
        data_write   = 1'b0;
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] m);
        data_address = addr;
        data_wdata   = wd;
        data_mask    = m;
        data_write   = 1'b1;
    endtask

    initial begin
        rst          = 1'b0;
        inst_address = '0;
        inst_read    = 1'b1;
        data_address = '0;
        data_read    = 1'b1;
        data_write   = 1'b0;
        data_wdata   = '0;
        data_mask    = '0;

        dut.inst_mem.r_mem[0]  = 32'h34011234;
        dut.inst_mem.r_mem[1]  = 32'h34020000;
        dut.inst_mem.r_mem[2]  = 32'h00000000;
        dut.data_ram.r_mem[4]  = 32'h00000000;
        dut.data_ram.r_mem[8]  = 32'h11111111;
        dut.data_ram.r_mem[12] = 32'h12345678;

        // In reset: outputs forced to zero even with requests asserted.
        #1;
        check("rst_inst_rdata", inst_rdata, 32'h0);
        check("rst_data_rdata", data_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        inst_address = 32'h0; #1;
        check("fetch0", inst_rdata, 32'h34011234);
        inst_address = 32'h4; #1;
        check("fetch1", inst_rdata, 32'h34020000);
        inst_address = 32'h8; #1;
        check("fetch2", inst_rdata, 32'h00000000);
        check("inst_stall", {31'b0, inst_stall}, 32'h0);
        check("data_stall", {31'b0, data_stall}, 32'h0);
        inst_read = 1'b0; #1;
        check("fetch_noread", inst_rdata, 32'h0);
        inst_read = 1'b1;

        // Full-word store then load.
        @(negedge clk);
        store(32'h10, 32'hDEADBEEF, 4'b1111); #1;
        check("full_data_w", data_w, 32'hDEADBEEF);
        @(negedge clk);
        load(32'h10);
        check("full_load", data_rdata, 32'hDEADBEEF);

        // Single-lane stores.
        store(32'h10, 32'h00AA0000, 4'b0100); #1;
        check("lane2_data_w", data_w, 32'hDEAABEEF);
        @(negedge clk);
        load(32'h10);
        check("lane2_load", data_rdata, 32'hDEAABEEF);
        store(32'h10, 32'h00000011, 4'b0001);
        @(negedge clk);
        load(32'h10);
        check("lane0_load", data_rdata, 32'hDEAABE11);
        store(32'h10, 32'hFFFFFFFF, 4'b0000); #1;
        check("nomask_data_w", data_w, 32'hDEAABE11);
        @(negedge clk);
        load(32'h10);
        check("nomask_load", data_rdata, 32'hDEAABE11);
        data_read = 1'b0; #1;
        check("load_noread", data_rdata, 32'h0);

        // Byte offset ignored; upper address bits alias.
        load(32'h13);
        check("alias_offset", data_rdata, 32'hDEAABE11);
        load(32'h00040010);
        check("alias_wrap", data_rdata, 32'hDEAABE11);

        // Read and write of the same word in one cycle.
        store(32'h20, 32'h22222222, 4'b1111);
        data_read = 1'b1; #1;
        check("rw_old", data_rdata, 32'h11111111);
        @(negedge clk);
        load(32'h20);
        check("rw_new", data_rdata, 32'h22222222);

        // Reset asserted mid-cycle during a store.
        inst_address = 32'h0;
        store(32'h30, 32'hFFFFFFFF, 4'b1111);
        data_read = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_inst_rdata", inst_rdata, 32'h0);
        check("midrst_data_rdata", data_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        data_write = 1'b0;
        rst = 1'b1;
        load(32'h30);
        check("midrst_no_write", data_rdata, 32'h12345678);
        check("midrst_inst_kept", inst_rdata, 32'h34011234);
        load(32'h10);
        check("midrst_data_kept", data_rdata, 32'hDEAABE11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
